// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start bit, LSB-first data, optional parity, one stop bit, Prescale clk per bit.
module uart_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      BUSY
);
  localparam int IW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d, pre_q, pre_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                      tx_q, tx_d, busy_q, busy_d;
  logic                      last, par_bit;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    pre_d     = pre_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    last      = cnt_q == pre_q - 1'b1;
    par_bit   = par_typ_q ? ~^data_q : ^data_q;
    if (state_q == IDLE) begin
      if (!busy_q && DATA_VALID) begin
        state_d   = START;
        cnt_d     = '0;
        data_d    = P_DATA;
        par_en_d  = PAR_EN;
        par_typ_d = PAR_TYP;
        pre_d     = (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
      end
    end else begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        idx_d   = (state_q == DATA) ? idx_q + 1'b1 : '0;
        state_d = (state_q == START)  ? DATA :
                  (state_q == DATA)   ? ((idx_q == IW'(DATA_WIDTH-1)) ? (par_en_q ? PARITY : STOP) : DATA) :
                  (state_q == PARITY) ? STOP : IDLE;
      end
    end
    // Output is registered, so it is derived from the state being entered.
    tx_d   = (state_d == START)  ? 1'b0 :
             (state_d == DATA)   ? data_q[idx_d] :
             (state_d == PARITY) ? par_bit : 1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      pre_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      pre_q     <= pre_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end
  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: cycle-exact scoreboard of {TX_OUT,BUSY} per clk, table-driven frames plus corner sequences.
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst, DATA_VALID, PAR_EN, PAR_TYP;
  logic [7:0] P_DATA;
  logic [5:0] Prescale;
  logic       TX_OUT, BUSY;
  int         n_cmp = 0, n_bad = 0, cyc = 0;
  string      name = "reset";

  typedef struct packed {logic tx; logic busy;} exp_t;
  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic [5:0] ps;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  uart_tx dut (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .Prescale(Prescale), .TX_OUT(TX_OUT), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  // Empty scoreboard means the line must be idle.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'(2'b10);
    n_cmp++;
    if ({TX_OUT, BUSY} !== e) begin
      n_bad++;
      $display("FAIL %s cyc=%0d tx/busy got=%b%b exp=%b%b", name, cyc, TX_OUT, BUSY, e.tx, e.busy);
    end
  endtask

  task automatic push_bit(input logic b, input int p);
    repeat (p) exp_q.push_back(exp_t'({b, 1'b1}));
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic par, input logic [5:0] ps);
    int p = (ps == 6'd0) ? 1 : int'(ps);
    push_bit(1'b0, p);
    for (int i = 0; i < 8; i++) push_bit(d[i], p);
    if (pe) push_bit(par, p);
    push_bit(1'b1, p);
  endtask

  // Scrambles inputs after acceptance and pulses DATA_VALID mid-frame; neither may affect the frame.
  task automatic run_row(input vec_t v);
    int len = 0;
    P_DATA = v.data; PAR_EN = v.pe; PAR_TYP = v.pt; Prescale = v.ps; DATA_VALID = 1'b1;
    push_frame(v.data, v.pe, v.exp_par, v.ps);
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!BUSY) break;
      len++;
      if (len == 1) begin
        DATA_VALID = 1'b0; P_DATA = ~v.data; PAR_EN = ~v.pe; PAR_TYP = ~v.pt; Prescale = v.ps + 6'd5;
      end
      if (len == 3) DATA_VALID = 1'b1;
      if (len == 4) DATA_VALID = 1'b0;
    end
    n_cmp++;
    if (len != v.exp_len) begin
      n_bad++;
      $display("FAIL %s busy_len got=%0d exp=%0d", name, len, v.exp_len);
    end
    exp_q.delete();
    tick();
  endtask

  initial begin
    vecs[0] = '{8'h45, 1'b0, 1'b0, 6'd8,  80,  1'b0};
    vecs[1] = '{8'hAA, 1'b1, 1'b1, 6'd8,  88,  1'b1};
    vecs[2] = '{8'hA8, 1'b1, 1'b0, 6'd16, 176, 1'b1};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 6'd1,  11,  1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 6'd3,  33,  1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 6'd0,  10,  1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 6'd63, 693, 1'b0};
    vecs[7] = '{8'h5A, 1'b0, 1'b0, 6'd2,  20,  1'b0};
    rst = 1'b1; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; P_DATA = '0; Prescale = 6'd8;
    @(negedge clk);
    tick();
    rst = 1'b0;
    name = "idle";
    repeat (3) tick();

    for (int r = 0; r < 8; r++) begin
      name = $sformatf("row%0d", r);
      run_row(vecs[r]);
    end

    name = "b2b";
    P_DATA = 8'h0F; PAR_EN = 1'b0; Prescale = 6'd4; DATA_VALID = 1'b1;
    push_frame(8'h0F, 1'b0, 1'b0, 6'd4);
    exp_q.push_back(exp_t'(2'b10));
    push_frame(8'hF0, 1'b0, 1'b0, 6'd4);
    tick();
    P_DATA = 8'hF0; Prescale = 6'd9;
    repeat (5) tick();
    Prescale = 6'd4;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      tick();
      if (exp_q.size() < 40) DATA_VALID = 1'b0;
    end
    DATA_VALID = 1'b0;
    exp_q.delete();
    repeat (2) tick();

    name = "rst_mid";
    P_DATA = 8'h55; PAR_EN = 1'b0; Prescale = 6'd4; DATA_VALID = 1'b1;
    push_frame(8'h55, 1'b0, 1'b0, 6'd4);
    tick();
    DATA_VALID = 1'b0;
    repeat (17) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    name = "after_rst";
    run_row('{8'h55, 1'b0, 1'b0, 6'd4, 40, 1'b0});

    name = "rst_vs_valid";
    rst = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'h33;
    tick();
    rst = 1'b0; DATA_VALID = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
